// File: rtl/ctl_trap_pkg.sv
// Shared types and constants for the Sodor trap/stall controller.
package ctl_trap_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DWAIT = 1'b1
  } state_e;

  localparam logic [2:0] PC_PLUS4 = 3'h0;
  localparam logic [2:0] PC_EXC   = 3'h4;

  localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'd0;
  localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;
  localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

endpackage

// File: rtl/ctl_prio_enc.sv
// Highest-set-bit priority encoder: idx of the MSB set in req, vld when any bit set.
module ctl_prio_enc #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx = IW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctl_trap_unit.sv
// Trap/stall controller: latched interrupts, prioritised cause encoding, dmem miss FSM, holdoff.
// Optional dmem response timeout enabled by defining CTL_DMEM_TIMEOUT_EN.
module ctl_trap_unit
  import ctl_trap_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_IRQ  = 3,
  parameter int IRQ_BASE = 3,
  parameter int HOLDOFF  = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_dat_imiss,
  input  logic               io_dat_inst_misaligned,
  input  logic               io_dat_illegal,
  input  logic               io_dat_ecall,
  input  logic               io_dat_mem_misaligned,
  input  logic               io_dat_mem_store,
  input  logic [NUM_IRQ-1:0] io_dat_irq,
  input  logic [NUM_IRQ-1:0] io_dat_irq_en,
  input  logic               io_dat_mie,
  input  logic               io_dmem_req_valid,
  input  logic               io_dmem_resp_valid,
  output logic               io_ctl_stall,
  output logic               io_ctl_dmiss,
  output logic [2:0]         io_ctl_pc_sel,
  output logic [2:0]         io_ctl_pc_sel_no_xept,
  output logic               io_ctl_exception,
  output logic [XLEN-1:0]    io_ctl_exception_cause,
  output logic               io_ctl_trap_valid,
  output logic [NUM_IRQ-1:0] io_ctl_irq_pending,
  output logic [XLEN-1:0]    io_ctl_last_cause
);

  localparam int IDX_W  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int HOLD_W = $clog2(HOLDOFF + 2);

  state_e              state_q, state_d;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [HOLD_W-1:0]   holdoff_q, holdoff_d;
  logic [XLEN-1:0]     last_cause_q, last_cause_d;

  logic                dmiss, take_ok, exc_raw, exception, irq_take, trap_valid;
  logic [3:0]          exc_cause, tmo_cause;
  logic                timeout;
  logic [IDX_W-1:0]    irq_idx;
  logic                irq_vld;
  logic [XLEN-2:0]     irq_code;
  logic [XLEN-1:0]     cause;

`ifdef CTL_DMEM_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             store_q, store_d;

  // Store/load flavour is latched on DWAIT entry so the fault cause matches the stalled access.
  always_comb begin
    timeout   = (state_q == DWAIT) && !io_dmem_resp_valid && (timer_q == TMR_W'(TIMEOUT - 1));
    timer_d   = ((state_q == DWAIT) && !io_dmem_resp_valid && !timeout) ? timer_q + 1'b1 : '0;
    store_d   = ((state_q == RUN) && io_dmem_req_valid && !io_dmem_resp_valid)
                ? io_dat_mem_store : store_q;
    tmo_cause = store_q ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
      store_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      store_q <= store_d;
    end
  end
`else
  logic timeout_cfg_unused;
  assign timeout_cfg_unused = ^TIMEOUT;
  assign timeout   = 1'b0;
  assign tmo_cause = CAUSE_LOAD_FAULT;
`endif

  always_comb begin
    state_d = state_q;
    dmiss   = 1'b0;
    case (state_q)
      RUN: begin
        if (io_dmem_req_valid && !io_dmem_resp_valid) begin
          state_d = DWAIT;
          dmiss   = 1'b1;
        end
      end
      DWAIT: begin
        if (io_dmem_resp_valid || timeout) state_d = RUN;
        else                               dmiss   = 1'b1;
      end
    endcase
  end

  always_comb begin
    exc_raw   = 1'b1;
    exc_cause = CAUSE_MISALIGNED_FETCH;
    if (io_dat_inst_misaligned)     exc_cause = CAUSE_MISALIGNED_FETCH;
    else if (io_dat_illegal)        exc_cause = CAUSE_ILLEGAL;
    else if (io_dat_ecall)          exc_cause = CAUSE_ECALL_M;
    else if (io_dat_mem_misaligned) exc_cause = io_dat_mem_store ? CAUSE_STORE_MISALIGNED
                                                                 : CAUSE_LOAD_MISALIGNED;
    else                            exc_raw   = 1'b0;
  end

  ctl_prio_enc #(.N(NUM_IRQ), .IW(IDX_W)) u_irq_enc (
    .req (pending_q & io_dat_irq_en),
    .idx (irq_idx),
    .vld (irq_vld)
  );

  always_comb begin
    take_ok    = (state_q == RUN) && !io_dat_imiss && !dmiss;
    exception  = (take_ok && exc_raw) || timeout;
    irq_take   = take_ok && !exc_raw && io_dat_mie && (holdoff_q == '0) && irq_vld;
    trap_valid = exception || irq_take;
    irq_code   = (XLEN-1)'(IRQ_BASE + 4 * int'(irq_idx));

    cause = '0;
    if (timeout)        cause = {{(XLEN-4){1'b0}}, tmo_cause};
    else if (exception) cause = {{(XLEN-4){1'b0}}, exc_cause};
    else if (irq_take)  cause = {1'b1, irq_code};

    // A line re-raised in the take cycle stays pending: the OR with irq comes after the clear.
    pending_d = pending_q;
    if (irq_take) pending_d = pending_q & ~(NUM_IRQ'(1) << irq_idx);
    pending_d = pending_d | io_dat_irq;

    if (trap_valid)            holdoff_d = HOLD_W'(HOLDOFF);
    else if (holdoff_q != '0)  holdoff_d = holdoff_q - 1'b1;
    else                       holdoff_d = holdoff_q;

    last_cause_d = trap_valid ? cause : last_cause_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= RUN;
      pending_q    <= '0;
      holdoff_q    <= '0;
      last_cause_q <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      holdoff_q    <= holdoff_d;
      last_cause_q <= last_cause_d;
    end
  end

  assign io_ctl_stall           = io_dat_imiss | dmiss;
  assign io_ctl_dmiss           = dmiss;
  assign io_ctl_pc_sel          = trap_valid ? PC_EXC : PC_PLUS4;
  assign io_ctl_pc_sel_no_xept  = irq_take ? PC_EXC : PC_PLUS4;
  assign io_ctl_exception       = exception;
  assign io_ctl_exception_cause = cause;
  assign io_ctl_trap_valid      = trap_valid;
  assign io_ctl_irq_pending     = pending_q;
  assign io_ctl_last_cause      = last_cause_q;

endmodule
